// File: rtl/acc_pkg.sv
// Shared defaults and helpers for the accumulation-path blocks.
// The adder2 saturation option is selected with the ADDER_ARB_SAT_EN macro.
package acc_pkg;

  localparam int DEFAULT_DATA_BITWIDTH = 16;
  localparam int DEFAULT_NUM_REQ       = 4;

  // Width of a requester index; never below one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder2.sv
// Two-operand unsigned adder with carry-out.
// ADDER_ARB_SAT_EN defined: the sum saturates to all-ones on carry; otherwise it wraps.
module adder2 #(
  parameter int DATA_BITWIDTH = 16
) (
  input  logic [DATA_BITWIDTH-1:0] i_left,
  input  logic [DATA_BITWIDTH-1:0] i_right,
  output logic [DATA_BITWIDTH-1:0] o_sum,
  output logic                     o_carry
);

  logic [DATA_BITWIDTH:0] w_full;

  assign w_full  = {1'b0, i_left} + {1'b0, i_right};
  assign o_carry = w_full[DATA_BITWIDTH];

`ifdef ADDER_ARB_SAT_EN
  assign o_sum = o_carry ? {DATA_BITWIDTH{1'b1}} : w_full[DATA_BITWIDTH-1:0];
`else
  assign o_sum = w_full[DATA_BITWIDTH-1:0];
`endif

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder2 among NUM_REQ requesters, with a single-entry
// output stage. ADDER_ARB_SAT_EN (in adder2) selects saturating instead of wrapping sums.
module adder_arbiter
  import acc_pkg::*;
#(
  parameter  int DATA_BITWIDTH = DEFAULT_DATA_BITWIDTH,
  parameter  int NUM_REQ       = DEFAULT_NUM_REQ,
  localparam int ID_BITWIDTH   = id_width(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*DATA_BITWIDTH-1:0] req_left,
  input  logic [NUM_REQ*DATA_BITWIDTH-1:0] req_right,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_BITWIDTH-1:0]         out_data,
  output logic [ID_BITWIDTH-1:0]           out_id,
  output logic                             out_ovf
);

  logic                     r_out_valid;
  logic [DATA_BITWIDTH-1:0] r_out_data;
  logic [ID_BITWIDTH-1:0]   r_out_id;
  logic                     r_out_ovf;
  logic [ID_BITWIDTH-1:0]   r_rr_ptr;

  logic                     w_can_accept;
  logic                     w_found;
  logic [ID_BITWIDTH-1:0]   w_grant_id;
  logic [ID_BITWIDTH-1:0]   w_ptr_next;
  logic                     w_xfer;
  logic [DATA_BITWIDTH-1:0] w_left;
  logic [DATA_BITWIDTH-1:0] w_right;
  logic [DATA_BITWIDTH-1:0] w_sum;
  logic                     w_carry;

  assign w_can_accept = !r_out_valid || out_ready;

  // Circular search from r_rr_ptr; the first valid requester wins.
  always_comb begin
    int idx;
    idx        = 0;
    w_found    = 1'b0;
    w_grant_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found    = 1'b1;
        w_grant_id = ID_BITWIDTH'(idx);
      end
    end
  end

  // Ready is also gated by reset so a pending grant vanishes while rst_n is low.
  assign req_ready = (rst_n && w_found && w_can_accept) ?
                     (NUM_REQ'(1) << w_grant_id) : '0;
  assign w_xfer    = |(req_valid & req_ready);

  assign w_ptr_next = (w_grant_id == ID_BITWIDTH'(NUM_REQ - 1)) ?
                      '0 : w_grant_id + ID_BITWIDTH'(1);

  assign w_left  = req_left [w_grant_id*DATA_BITWIDTH +: DATA_BITWIDTH];
  assign w_right = req_right[w_grant_id*DATA_BITWIDTH +: DATA_BITWIDTH];

  adder2 #(
    .DATA_BITWIDTH(DATA_BITWIDTH)
  ) u_adder2 (
    .i_left  (w_left),
    .i_right (w_right),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_out_ovf   <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sum;
      r_out_id    <= w_grant_id;
      r_out_ovf   <= w_carry;
      r_rr_ptr    <= w_ptr_next;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter (4 requesters) plus a 3-requester instance for wrap.
module tb_adder_arbiter;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  id;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_left = '0;
  logic [63:0] req_right = '0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [1:0]  out_id;
  logic        out_ovf;

  logic [2:0]  v3 = '0;
  logic [47:0] l3 = '0;
  logic [47:0] r3 = '0;
  logic [2:0]  ready3;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;
  logic [15:0] out_data3;
  logic [1:0]  out_id3;
  logic        out_ovf3;

  int   n_cmp = 0;
  int   n_err = 0;
  int   m_ptr = 0;
  bit   m_valid = 0;
  res_t sb_q[$];

  always #5 clk = ~clk;

  adder_arbiter #(.DATA_BITWIDTH(16), .NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_left(req_left),
    .req_right(req_right), .req_ready(req_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id), .out_ovf(out_ovf)
  );

  adder_arbiter #(.DATA_BITWIDTH(16), .NUM_REQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_left(l3),
    .req_right(r3), .req_ready(ready3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(out_data3), .out_id(out_id3), .out_ovf(out_ovf3)
  );

  function automatic logic [3:0] exp_grant(input logic [3:0] v, input int ptr, input bit can);
    if (!can) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (ptr + k) % 4;
      if (v[i]) return 4'b0001 << i;
    end
    return 4'b0000;
  endfunction

  function automatic res_t exp_res(input logic [15:0] a, input logic [15:0] b, input int id);
    res_t r;
    logic [16:0] s;
    s     = {1'b0, a} + {1'b0, b};
    r.ovf = s[16];
    r.id  = id[1:0];
`ifdef ADDER_ARB_SAT_EN
    r.data = s[16] ? 16'hFFFF : s[15:0];
`else
    r.data = s[15:0];
`endif
    return r;
  endfunction

  // Advance the reference model across one rising edge, then park at the falling edge.
  task automatic step();
    logic [3:0] g;
    g = exp_grant(req_valid, m_ptr, !m_valid || out_ready);
    if (m_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
    if (g != 4'b0000) begin
      for (int i = 0; i < 4; i++)
        if (g[i]) begin
          sb_q.push_back(exp_res(req_left[i*16 +: 16], req_right[i*16 +: 16], i));
          m_ptr = (i + 1) % 4;
        end
      m_valid = 1;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_id, out_ovf} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b d=%h id=%0d o=%b want all 0", out_valid, out_data, out_id, out_ovf);
    end
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ready got %b want 0000", req_ready);
    end
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [3:0] g;
    req_valid = 4'b0001;
    req_left[15:0] = 16'd3;
    req_right[15:0] = 16'd5;
    out_ready = 1'b1;
    #1;
    g = exp_grant(req_valid, m_ptr, !m_valid || out_ready);
    n_cmp++;
    if (req_ready !== g || g !== 4'b0001) begin
      n_err++;
      $display("FAIL single_ready got %b want 0001", req_ready);
    end
    step();
    req_valid = 4'b0000;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_id, out_ovf} !== {1'b1, sb_q[0].data, sb_q[0].id, sb_q[0].ovf}) begin
      n_err++;
      $display("FAIL single_result got v=%b d=%0d id=%0d o=%b want v=1 d=%0d id=%0d o=%b",
               out_valid, out_data, out_id, out_ovf, sb_q[0].data, sb_q[0].id, sb_q[0].ovf);
    end
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_ready got %b want 0000", req_ready);
    end
    step();
    step();
    req_valid = 4'b1111;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL idle_ptr got v=%b ready=%b want v=0 ready=0010", out_valid, req_ready);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) begin
        req_left[i*16 +: 16]  = 16'($urandom_range(0, 65535));
        req_right[i*16 +: 16] = 16'($urandom_range(0, 65535));
      end
      #1;
      g = exp_grant(req_valid, m_ptr, !m_valid || out_ready);
      n_cmp++;
      if (req_ready !== g) begin
        n_err++;
        $display("FAIL rr_grant cycle %0d got %b want %b", c, req_ready, g);
      end
      if (m_valid) begin
        n_cmp++;
        if ({out_valid, out_data, out_id, out_ovf} !== {1'b1, sb_q[0].data, sb_q[0].id, sb_q[0].ovf}) begin
          n_err++;
          $display("FAIL rr_result cycle %0d got v=%b d=%h id=%0d o=%b want v=1 d=%h id=%0d o=%b", c,
                   out_valid, out_data, out_id, out_ovf, sb_q[0].data, sb_q[0].id, sb_q[0].ovf);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] g;
    res_t held;
    req_valid = 4'b0110;
    out_ready = 1'b0;
    held = sb_q[0];
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'b0000 ||
          {out_valid, out_data, out_id, out_ovf} !== {1'b1, held.data, held.id, held.ovf}) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d got ready=%b v=%b d=%h id=%0d want ready=0000 v=1 d=%h id=%0d",
                 c, req_ready, out_valid, out_data, out_id, held.data, held.id);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    g = exp_grant(req_valid, m_ptr, 1'b1);
    n_cmp++;
    if (req_ready !== g) begin
      n_err++;
      $display("FAIL bp_release got %b want %b (last id %0d)", req_ready, g, held.id);
    end
    step();
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_overflow();
    req_valid = 4'b1000;
    req_left[48 +: 16]  = 16'hFFFF;
    req_right[48 +: 16] = 16'h0002;
    out_ready = 1'b1;
    step();
    req_valid = 4'b0000;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_id, out_ovf} !== {1'b1, sb_q[0].data, sb_q[0].id, sb_q[0].ovf} ||
        out_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL overflow got v=%b d=%h id=%0d o=%b want v=1 d=%h id=3 o=1",
               out_valid, out_data, out_id, out_ovf, sb_q[0].data);
    end
    step();
  endtask

  task automatic test_async_reset();
    req_valid = 4'b0001;
    req_left[15:0]  = 16'h1234;
    req_right[15:0] = 16'h0101;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_id, out_ovf} !== 20'd0 || req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset got v=%b d=%h id=%0d o=%b ready=%b want all 0",
               out_valid, out_data, out_id, out_ovf, req_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL post_reset_grant got %b want 0100", req_ready);
    end
    step();
    req_valid = 4'b0000;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_id} !== {1'b1, sb_q[0].data, sb_q[0].id}) begin
      n_err++;
      $display("FAIL post_reset_result got v=%b d=%h id=%0d want v=1 d=%h id=%0d",
               out_valid, out_data, out_id, sb_q[0].data, sb_q[0].id);
    end
    step();
  endtask

  task automatic test_wrap3();
    v3 = 3'b100;
    l3[32 +: 16] = 16'd7;
    r3[32 +: 16] = 16'd1;
    l3[0 +: 16]  = 16'd10;
    r3[0 +: 16]  = 16'd20;
    #1;
    n_cmp++;
    if (ready3 !== 3'b100) begin
      n_err++;
      $display("FAIL wrap3_first got %b want 100", ready3);
    end
    @(posedge clk);
    @(negedge clk);
    v3 = 3'b011;
    #1;
    n_cmp++;
    if ({out_valid3, out_data3, out_id3} !== {1'b1, 16'd8, 2'd2}) begin
      n_err++;
      $display("FAIL wrap3_result got v=%b d=%0d id=%0d want v=1 d=8 id=2", out_valid3, out_data3, out_id3);
    end
    n_cmp++;
    if (ready3 !== 3'b001) begin
      n_err++;
      $display("FAIL wrap3_next got %b want 001", ready3);
    end
    @(posedge clk);
    @(negedge clk);
    v3 = 3'b000;
    #1;
    n_cmp++;
    if ({out_valid3, out_data3, out_id3} !== {1'b1, 16'd30, 2'd0}) begin
      n_err++;
      $display("FAIL wrap3_second got v=%b d=%0d id=%0d want v=1 d=30 id=0", out_valid3, out_data3, out_id3);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_async_reset();
    test_wrap3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
